cmd_sched: RTL and testbench
============================

CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter DEPTH, default 8, meaning command queue depth in entries; SHALL be a power of two, 2..64.
REQ-002 Parameter GUARD, default 48, meaning minimum lead time in CLK cycles between issue time and MEM_TIME_START.
REQ-003 CLK  input  1  clock, 48 MHz system clock.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 CMD_WR  input  1  host push strobe, one entry per high cycle.
REQ-006 CMD_IN  input  338  packed command, MSB to LSB: freq[48], delta_freq[48], delta_rate[32], time_start[64], n_impuls[16], type[2], Ti[32], Tp[32], Tblank1[32], Tblank2[32].
REQ-007 TIME  input  64  current system time from the pulse master.
REQ-008 SYS_TIME_UPDATE_OK  input  1  high when system time is synchronised.
REQ-009 REQ_COMMAND  input  1  pulse master command-in-progress flag.
REQ-010 WR_DATA  output  1  one-cycle load strobe to the pulse master.
REQ-011 MEM_DDS_freq/MEM_DDS_delta_freq/MEM_DDS_delta_rate/MEM_TIME_START/MEM_N_impuls/MEM_TYPE_impulse/MEM_Interval_Ti/MEM_Interval_Tp/MEM_Tblank1/MEM_Tblank2  output  48/48/32/64/16/2/32/32/32/32  unpacked fields of the issued command.
REQ-012 FULL, EMPTY  output  1 each  queue status.
REQ-013 LEVEL  output  log2(DEPTH)+1  entries stored.
REQ-014 OVF  output  1  sticky: a push was attempted while FULL.
REQ-015 STALE_CNT  output  8  count of dropped stale commands, saturating at 255.
REQ-016 BUSY  output  1  high in every state except S_IDLE.

Function
REQ-017 Push: CMD_WR high and FULL low SHALL store CMD_IN at the write pointer and increment LEVEL on the same edge.
REQ-018 CMD_WR high while FULL SHALL discard the data, leave the queue unchanged and set OVF.
REQ-019 Pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL both take effect with LEVEL unchanged.
REQ-020 FSM states: S_IDLE, S_POP, S_CHECK, S_ARMED, S_BUSY.
REQ-021 S_IDLE -> S_POP when SYS_TIME_UPDATE_OK=1 and EMPTY=0.
REQ-022 S_POP: latch the head entry into the MEM_* output registers, pop one entry, then -> S_CHECK.
REQ-023 S_CHECK: a stale command (REQ-034) SHALL increment STALE_CNT, leave WR_DATA low and -> S_IDLE; otherwise WR_DATA high for exactly this cycle, then -> S_ARMED.
REQ-024 S_ARMED -> S_BUSY on a rising edge of REQ_COMMAND, detected against a one-cycle registered copy.
REQ-025 S_BUSY -> S_IDLE on a falling edge of REQ_COMMAND (burst finished); the next command SHALL NOT be issued before this edge.
REQ-026 In S_ARMED or S_BUSY, SYS_TIME_UPDATE_OK=0 SHALL force -> S_IDLE without issuing; the armed command is lost and the next queue entry is used after resynchronisation.
REQ-027 Latency: with the queue empty, the FSM in S_IDLE and SYS_TIME_UPDATE_OK=1, WR_DATA SHALL be high on the 3rd CLK edge after the edge that accepts CMD_WR.
REQ-028 MEM_* outputs SHALL hold their value between issues; they change only in S_POP.
REQ-029 Pushes SHALL be accepted in every FSM state, including while SYS_TIME_UPDATE_OK=0.

Reset
REQ-030 RESET SHALL clear both pointers, set LEVEL to 0 (EMPTY=1, FULL=0) and clear OVF and STALE_CNT.
REQ-031 RESET SHALL force the FSM to S_IDLE, set WR_DATA=0 and BUSY=0, and clear the REQ_COMMAND edge register.
REQ-032 RESET SHALL set all MEM_* outputs to all-ones; the time_start field all-ones means "never".
REQ-033 A reset asserted mid-operation SHALL discard all queued and armed commands, with no WR_DATA pulse in the reset cycle.

Configuration
REQ-034 With macro CMD_SCHED_STALE_CHECK_EN defined, a command is stale when MEM_TIME_START <= TIME + GUARD, as an unsigned 64-bit compare with wrap-around of the sum ignored.
REQ-035 Without CMD_SCHED_STALE_CHECK_EN, S_CHECK SHALL always issue, and STALE_CNT SHALL be tied to 0.

Verification
REQ-036 Scenario: SYS_OK=1, push 1 command with time_start=TIME+1000 -> WR_DATA is a single pulse 3 cycles later and the MEM_* fields match CMD_IN.
REQ-037 Scenario: push 9 commands with DEPTH=8 -> FULL after the 8th push, OVF=1, LEVEL=8, and the 9th command is never issued.
REQ-038 Scenario: 2 queued commands, REQ_COMMAND rises then falls 500 cycles later -> the 2nd WR_DATA pulse occurs only after the fall, exactly 3 cycles after it.
REQ-039 Scenario: STALE_CHECK_EN defined, push time_start=TIME+10 followed by a valid command -> STALE_CNT=1, and WR_DATA pulses once with the second command's fields.
REQ-040 Scenario: SYS_OK=0 with 3 commands pushed -> no WR_DATA and LEVEL=3; SYS_OK rises -> issue follows.
REQ-041 Scenario: RESET in S_BUSY with LEVEL=4 -> next cycle LEVEL=0, BUSY=0 and all MEM_* outputs all-ones.

Source files
------------

// File: rtl/cmd_sched_if.sv
// Host/pulse-master side bundle for cmd_sched: command push port, time inputs,
// issued-command register outputs and queue status.
interface cmd_sched_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          CMD_WR;
  logic [337:0]  CMD_IN;
  logic [63:0]   TIME;
  logic          SYS_TIME_UPDATE_OK;
  logic          REQ_COMMAND;

  logic          WR_DATA;
  logic [47:0]   MEM_DDS_freq;
  logic [47:0]   MEM_DDS_delta_freq;
  logic [31:0]   MEM_DDS_delta_rate;
  logic [63:0]   MEM_TIME_START;
  logic [15:0]   MEM_N_impuls;
  logic [1:0]    MEM_TYPE_impulse;
  logic [31:0]   MEM_Interval_Ti;
  logic [31:0]   MEM_Interval_Tp;
  logic [31:0]   MEM_Tblank1;
  logic [31:0]   MEM_Tblank2;
  logic          FULL;
  logic          EMPTY;
  logic [LW-1:0] LEVEL;
  logic          OVF;
  logic [7:0]    STALE_CNT;
  logic          BUSY;

  modport master (
    output CMD_WR, CMD_IN, TIME, SYS_TIME_UPDATE_OK, REQ_COMMAND,
    input  WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate,
           MEM_TIME_START, MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti,
           MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2, FULL, EMPTY, LEVEL,
           OVF, STALE_CNT, BUSY
  );

  modport slave (
    input  CMD_WR, CMD_IN, TIME, SYS_TIME_UPDATE_OK, REQ_COMMAND,
    output WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate,
           MEM_TIME_START, MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti,
           MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2, FULL, EMPTY, LEVEL,
           OVF, STALE_CNT, BUSY
  );
endinterface

// File: rtl/cmd_sched.sv
// Command queue + issue scheduler feeding the pulse master, one burst at a time.
// Optional stale-command dropping: define CMD_SCHED_STALE_CHECK_EN.
module cmd_sched #(
  parameter int DEPTH = 8,
  parameter int GUARD = 48
) (
  input logic       CLK,
  input logic       RESET,
  cmd_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 338;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_CHECK, S_ARMED, S_BUSY} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   queue_mem [DEPTH];
  logic [CW-1:0]   head_reg;
  logic [CW-1:0]   mem_out_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            ovf_reg;
  logic            req_q_reg;
  logic            full, empty, push, pop, stale, wr_data;
  logic            req_rise, req_fall;

  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign push     = bus.CMD_WR && !full;
  assign pop      = (state_reg == S_POP);
  assign req_rise = bus.REQ_COMMAND && !req_q_reg;
  assign req_fall = !bus.REQ_COMMAND && req_q_reg;

  // Reset-free storage so it maps onto block RAM; the head is read every cycle.
  always_ff @(posedge CLK) begin
    if (push)
      queue_mem[wr_ptr_reg] <= bus.CMD_IN;
    head_reg <= queue_mem[rd_ptr_reg];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
      req_q_reg  <= 1'b0;
    end else begin
      req_q_reg <= bus.REQ_COMMAND;
      if (bus.CMD_WR && full)
        ovf_reg <= 1'b1;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // All-ones time_start after reset reads as "never".
  always_ff @(posedge CLK) begin
    if (RESET)
      mem_out_reg <= '1;
    else if (pop)
      mem_out_reg <= head_reg;
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wr_data    = 1'b0;
    case (state_reg)
      S_IDLE:  if (bus.SYS_TIME_UPDATE_OK && !empty) state_next = S_POP;
      S_POP:   state_next = S_CHECK;
      S_CHECK: begin
        if (stale) begin
          state_next = S_IDLE;
        end else begin
          wr_data    = 1'b1;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!bus.SYS_TIME_UPDATE_OK) state_next = S_IDLE;
        else if (req_rise)           state_next = S_BUSY;
      end
      S_BUSY: begin
        if (!bus.SYS_TIME_UPDATE_OK) state_next = S_IDLE;
        else if (req_fall)           state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CMD_SCHED_STALE_CHECK_EN
  logic [63:0] deadline;
  logic [7:0]  stale_cnt_reg;

  // Sum wraps silently; a wrapped deadline simply compares low.
  assign deadline = bus.TIME + 64'(GUARD);
  assign stale    = (mem_out_reg[209:146] <= deadline);

  always_ff @(posedge CLK) begin
    if (RESET)
      stale_cnt_reg <= '0;
    else if (state_reg == S_CHECK && stale && stale_cnt_reg != 8'hFF)
      stale_cnt_reg <= stale_cnt_reg + 8'd1;
  end

  assign bus.STALE_CNT = stale_cnt_reg;
`else
  logic [63:0] unused_deadline;

  assign unused_deadline = bus.TIME + 64'(GUARD);
  assign stale           = 1'b0;
  assign bus.STALE_CNT   = 8'd0;
`endif

  assign bus.WR_DATA            = wr_data && !RESET;
  assign bus.BUSY               = (state_reg != S_IDLE);
  assign bus.FULL               = full;
  assign bus.EMPTY              = empty;
  assign bus.LEVEL              = level_reg;
  assign bus.OVF                = ovf_reg;
  assign bus.MEM_DDS_freq       = mem_out_reg[337:290];
  assign bus.MEM_DDS_delta_freq = mem_out_reg[289:242];
  assign bus.MEM_DDS_delta_rate = mem_out_reg[241:210];
  assign bus.MEM_TIME_START     = mem_out_reg[209:146];
  assign bus.MEM_N_impuls       = mem_out_reg[145:130];
  assign bus.MEM_TYPE_impulse   = mem_out_reg[129:128];
  assign bus.MEM_Interval_Ti    = mem_out_reg[127:96];
  assign bus.MEM_Interval_Tp    = mem_out_reg[95:64];
  assign bus.MEM_Tblank1        = mem_out_reg[63:32];
  assign bus.MEM_Tblank2        = mem_out_reg[31:0];
endmodule

// File: tb/tb_cmd_sched.sv
// Scoreboard bench for cmd_sched: expected commands queued at push, checked on WR_DATA.
module tb_cmd_sched;
  localparam int DEPTH = 8;
  localparam int GUARD = 48;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CW    = 338;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   sys_time = 64'd100000;
  int            n_vec = 0;
  int            n_miss = 0;
  int            wr_count = 0;
  logic [CW-1:0] sb[$];
  logic [CW-1:0] mon_exp;
  logic [CW-1:0] all_ones;

  cmd_sched_if #(.DEPTH(DEPTH)) bus();

  cmd_sched #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sys_time <= sys_time + 64'd1;
  assign bus.TIME = sys_time;

  function automatic logic [CW-1:0] issued();
    return {bus.MEM_DDS_freq, bus.MEM_DDS_delta_freq, bus.MEM_DDS_delta_rate,
            bus.MEM_TIME_START, bus.MEM_N_impuls, bus.MEM_TYPE_impulse,
            bus.MEM_Interval_Ti, bus.MEM_Interval_Tp, bus.MEM_Tblank1, bus.MEM_Tblank2};
  endfunction

  function automatic logic [CW-1:0] make_cmd(input logic [63:0] ts);
    logic [CW-1:0] c;
    for (int i = 0; i < CW; i++) c[i] = 1'($urandom_range(1));
    c[209:146] = ts;
    return c;
  endfunction

  // Every issue is checked against the oldest expected command.
  always @(negedge clk) begin
    if (bus.WR_DATA === 1'b1) begin
      wr_count++;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_issue: got WR_DATA=1 required no issue");
      end else begin
        mon_exp = sb.pop_front();
        $display("issue %0d: time_start=%h", wr_count, bus.MEM_TIME_START);
        if (issued() !== mon_exp) begin
          n_miss++;
          $display("FAIL issued_fields: got %h required %h", issued(), mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.CMD_WR = 1'b0;
    bus.REQ_COMMAND = 1'b0;
    tick(2);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic push_cmd(input logic [CW-1:0] c, input bit exp_issue);
    bus.CMD_WR = 1'b1;
    bus.CMD_IN = c;
    if (exp_issue) sb.push_back(c);
    $display("push: time_start=%h expect_issue=%0d", c[209:146], exp_issue);
    @(negedge clk);
    bus.CMD_WR = 1'b0;
  endtask

  task automatic wait_wr(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.WR_DATA === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic burst(input int len);
    bus.REQ_COMMAND = 1'b1;
    tick(len);
    bus.REQ_COMMAND = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_vec++; if (bus.LEVEL !== LW'(0)) begin n_miss++; $display("FAIL reset_level: got %0d required 0", bus.LEVEL); end
    n_vec++; if (bus.EMPTY !== 1'b1) begin n_miss++; $display("FAIL reset_empty: got %b required 1", bus.EMPTY); end
    n_vec++; if (bus.FULL !== 1'b0) begin n_miss++; $display("FAIL reset_full: got %b required 0", bus.FULL); end
    n_vec++; if (bus.OVF !== 1'b0) begin n_miss++; $display("FAIL reset_ovf: got %b required 0", bus.OVF); end
    n_vec++; if (bus.STALE_CNT !== 8'd0) begin n_miss++; $display("FAIL reset_stale_cnt: got %0d required 0", bus.STALE_CNT); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b required 0", bus.BUSY); end
    n_vec++; if (bus.WR_DATA !== 1'b0) begin n_miss++; $display("FAIL reset_wr_data: got %b required 0", bus.WR_DATA); end
    n_vec++; if (issued() !== all_ones) begin n_miss++; $display("FAIL reset_mem: got %h required all ones", issued()); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    tick(1);
    push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    wait_wr(10, n);
    n_vec++; if (n != 2) begin n_miss++; $display("FAIL single_latency: got %0d required 2 (edges after accept: 3)", n); end
    tick(1);
    n_vec++; if (bus.WR_DATA !== 1'b0) begin n_miss++; $display("FAIL single_pulse_width: got %b required 0", bus.WR_DATA); end
    n_vec++; if (bus.BUSY !== 1'b1) begin n_miss++; $display("FAIL single_armed_busy: got %b required 1", bus.BUSY); end
    n_vec++; if (bus.LEVEL !== LW'(0)) begin n_miss++; $display("FAIL single_level: got %0d required 0", bus.LEVEL); end
    burst(3);
    tick(2);
    n_vec++; if (bus.BUSY !== 1'b0) begin n_miss++; $display("FAIL single_burst_done: got %b required 0", bus.BUSY); end
    n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL single_drained: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_full();
    int n;
    int w0;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b0;
    w0 = wr_count;
    for (int i = 0; i < 9; i++) begin
      push_cmd(make_cmd(sys_time + 64'd5000), i < 8);
      if (i == 7) begin
        n_vec++; if (bus.FULL !== 1'b1) begin n_miss++; $display("FAIL full_after_8: got %b required 1", bus.FULL); end
        n_vec++; if (bus.OVF !== 1'b0) begin n_miss++; $display("FAIL ovf_before_9: got %b required 0", bus.OVF); end
      end
    end
    n_vec++; if (bus.OVF !== 1'b1) begin n_miss++; $display("FAIL ovf_after_9: got %b required 1", bus.OVF); end
    n_vec++; if (bus.LEVEL !== LW'(8)) begin n_miss++; $display("FAIL full_level: got %0d required 8", bus.LEVEL); end
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_wr(10, n);
      n_vec++; if (n < 0) begin n_miss++; $display("FAIL full_drain_%0d: got no WR_DATA required issue", k); end
      tick(1);
      burst(2);
    end
    tick(20);
    n_vec++; if (wr_count - w0 != 8) begin n_miss++; $display("FAIL full_issue_count: got %0d required 8", wr_count - w0); end
    n_vec++; if (bus.EMPTY !== 1'b1) begin n_miss++; $display("FAIL full_empty_end: got %b required 1", bus.EMPTY); end
    n_vec++; if (bus.OVF !== 1'b1) begin n_miss++; $display("FAIL ovf_sticky: got %b required 1", bus.OVF); end
  endtask

  task automatic test_back_to_back();
    int n;
    int w0;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    wait_wr(10, n);
    n_vec++; if (n < 0) begin n_miss++; $display("FAIL b2b_first: got no WR_DATA required issue"); end
    tick(1);
    bus.REQ_COMMAND = 1'b1;
    w0 = wr_count;
    tick(500);
    n_vec++; if (wr_count != w0) begin n_miss++; $display("FAIL b2b_held: got %0d issues during burst required 0", wr_count - w0); end
    n_vec++; if (bus.LEVEL !== LW'(1)) begin n_miss++; $display("FAIL b2b_level: got %0d required 1", bus.LEVEL); end
    bus.REQ_COMMAND = 1'b0;
    wait_wr(10, n);
    n_vec++; if (n != 3) begin n_miss++; $display("FAIL b2b_after_fall: got %0d cycles required 3", n); end
    tick(1);
    burst(2);
    tick(2);
  endtask

  task automatic test_stale();
    int n;
    int w0;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    w0 = wr_count;
`ifdef CMD_SCHED_STALE_CHECK_EN
    push_cmd(make_cmd(sys_time + 64'd10), 1'b0);
    push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    wait_wr(20, n);
    n_vec++; if (n < 0) begin n_miss++; $display("FAIL stale_second_issue: got no WR_DATA required issue"); end
    n_vec++; if (bus.STALE_CNT !== 8'd1) begin n_miss++; $display("FAIL stale_cnt: got %0d required 1", bus.STALE_CNT); end
`else
    push_cmd(make_cmd(sys_time + 64'd10), 1'b1);
    wait_wr(10, n);
    n_vec++; if (n != 2) begin n_miss++; $display("FAIL near_time_issue: got %0d required 2", n); end
    n_vec++; if (bus.STALE_CNT !== 8'd0) begin n_miss++; $display("FAIL stale_cnt_tied: got %0d required 0", bus.STALE_CNT); end
`endif
    tick(1);
    burst(2);
    tick(5);
    n_vec++; if (wr_count - w0 != 1) begin n_miss++; $display("FAIL stale_issue_count: got %0d required 1", wr_count - w0); end
    n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL stale_drained: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_sys_ok();
    int n;
    int w0;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b0;
    w0 = wr_count;
    for (int i = 0; i < 3; i++) push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    tick(10);
    n_vec++; if (wr_count != w0) begin n_miss++; $display("FAIL sysok_no_issue: got %0d issues required 0", wr_count - w0); end
    n_vec++; if (bus.LEVEL !== LW'(3)) begin n_miss++; $display("FAIL sysok_level: got %0d required 3", bus.LEVEL); end
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    wait_wr(10, n);
    n_vec++; if (n != 2) begin n_miss++; $display("FAIL sysok_resume: got %0d required 2", n); end
    n_vec++; if (bus.LEVEL !== LW'(2)) begin n_miss++; $display("FAIL sysok_level_pop: got %0d required 2", bus.LEVEL); end
    // Losing sync while armed drops that command; the next entry follows.
    tick(1);
    bus.SYS_TIME_UPDATE_OK = 1'b0;
    tick(1);
    n_vec++; if (bus.BUSY !== 1'b0) begin n_miss++; $display("FAIL sysok_drop_idle: got %b required 0", bus.BUSY); end
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_wr(10, n);
      n_vec++; if (n < 0) begin n_miss++; $display("FAIL sysok_drain_%0d: got no WR_DATA required issue", k); end
      tick(1);
      burst(2);
    end
    tick(5);
    n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL sysok_drained: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_reset_busy();
    int n;
    int w0;
    do_reset();
    bus.SYS_TIME_UPDATE_OK = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(make_cmd(sys_time + 64'd5000), 1'b1);
    bus.SYS_TIME_UPDATE_OK = 1'b1;
    wait_wr(10, n);
    n_vec++; if (n < 0) begin n_miss++; $display("FAIL rstbusy_issue: got no WR_DATA required issue"); end
    tick(1);
    bus.REQ_COMMAND = 1'b1;
    tick(2);
    n_vec++; if (bus.BUSY !== 1'b1) begin n_miss++; $display("FAIL rstbusy_in_busy: got %b required 1", bus.BUSY); end
    n_vec++; if (bus.LEVEL !== LW'(4)) begin n_miss++; $display("FAIL rstbusy_level4: got %0d required 4", bus.LEVEL); end
    reset = 1'b1;
    tick(1);
    n_vec++; if (bus.LEVEL !== LW'(0)) begin n_miss++; $display("FAIL rstbusy_level0: got %0d required 0", bus.LEVEL); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_miss++; $display("FAIL rstbusy_busy: got %b required 0", bus.BUSY); end
    n_vec++; if (issued() !== all_ones) begin n_miss++; $display("FAIL rstbusy_mem: got %h required all ones", issued()); end
    reset = 1'b0;
    bus.REQ_COMMAND = 1'b0;
    sb.delete();
    w0 = wr_count;
    tick(20);
    n_vec++; if (wr_count != w0) begin n_miss++; $display("FAIL rstbusy_discard: got %0d issues required 0", wr_count - w0); end
  endtask

  initial begin
    all_ones = '1;
    bus.CMD_WR = 1'b0;
    bus.CMD_IN = '0;
    bus.SYS_TIME_UPDATE_OK = 1'b0;
    bus.REQ_COMMAND = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_stale();
    test_sys_ok();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end
endmodule
